// File: rtl/hazard_ctrl.sv
// Issue-stage hazard controller: DEPTH-entry destination scoreboard plus branch-penalty counter.
// Optional build macro HAZARD_FORWARD_EN: only a load in entry[0] can cause a RAW stall.
module hazard_ctrl #(
    parameter int DEPTH          = 3,
    parameter int BRANCH_PENALTY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [4:0]  dest,
    input  logic        isbranch,
    output logic        issue,
    output logic        stall,
    output logic [3:0]  inflight
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [3:0] BP_LOAD  = 4'(BRANCH_PENALTY);

    logic             r_valid [DEPTH];
    logic [4:0]       r_dest  [DEPTH];
    logic [3:0]       r_bcnt;

    logic [5:0]       w_opcode;
    logic             w_use_rs;
    logic             w_use_rt;
    logic [4:0]       w_src_rs;
    logic [4:0]       w_src_rt;
    logic             w_raw;
    logic             w_block;
    logic             w_issue;
    logic             w_is_lw;
    logic [DEPTH-1:0] w_hit;
    logic [3:0]       w_count;
    logic             w_unused;

    assign w_opcode = instr[31:26];
    assign w_is_lw  = (w_opcode == OP_LW);
    assign w_unused = ^{instr[15:0]};

    always_comb begin
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        case (w_opcode)
            OP_RTYPE, OP_BEQ, OP_SW: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            OP_ADDI, OP_LW: w_use_rs = 1'b1;
            OP_J:           w_use_rs = 1'b0;
            default:        w_use_rs = 1'b0;
        endcase
    end

    // Unused or $0 sources collapse to 0, which can never match a hazarding entry.
    assign w_src_rs = w_use_rs ? instr[25:21] : 5'd0;
    assign w_src_rt = w_use_rt ? instr[20:16] : 5'd0;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign w_hit[gi] = r_valid[gi] && (r_dest[gi] != 5'd0) &&
                               (((w_src_rs != 5'd0) && (r_dest[gi] == w_src_rs)) ||
                                ((w_src_rt != 5'd0) && (r_dest[gi] == w_src_rt)));
        end
    endgenerate

`ifdef HAZARD_FORWARD_EN
    logic r_load [DEPTH];

    // Forwarding covers every producer except a load one stage ahead.
    assign w_raw = w_hit[0] & r_load[0];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_load
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_load[gi] <= 1'b0;
                end else if (gi == 0) begin
                    r_load[gi] <= w_issue & w_is_lw;
                end else begin
                    r_load[gi] <= r_load[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate
`else
    assign w_raw = |w_hit;
    logic w_unused_lw;
    assign w_unused_lw = w_is_lw;
`endif

    assign w_block = w_raw | (r_bcnt != 4'd0);
    assign w_issue = ~reset & instr_valid & ~w_block;
    assign issue   = w_issue;
    assign stall   = ~reset & instr_valid & w_block;

    // Stalled or idle cycles push a bubble so the scoreboard keeps draining.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_valid[gi] <= 1'b0;
                    r_dest[gi]  <= 5'd0;
                end else if (gi == 0) begin
                    r_valid[gi] <= w_issue;
                    r_dest[gi]  <= w_issue ? dest : 5'd0;
                end else begin
                    r_valid[gi] <= r_valid[(gi > 0) ? gi - 1 : 0];
                    r_dest[gi]  <= r_dest[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcnt <= 4'd0;
        end else if (w_issue && isbranch) begin
            r_bcnt <= BP_LOAD;
        end else if (r_bcnt != 4'd0) begin
            r_bcnt <= r_bcnt - 4'd1;
        end
    end

    always_comb begin
        w_count = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + 4'(r_valid[i]);
        end
    end

    assign inflight = w_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl at DEPTH=3, BRANCH_PENALTY=2; expectations follow HAZARD_FORWARD_EN.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic [4:0]  dest;
    logic        isbranch;
    logic        issue;
    logic        stall;
    logic [3:0]  inflight;

    int checks = 0;
    int errors = 0;
    int infl_log [4];

`ifdef HAZARD_FORWARD_EN
    localparam int EXP_RAW_ALU  = 0;
    localparam int EXP_RAW_LOAD = 1;
`else
    localparam int EXP_RAW_ALU  = 3;
    localparam int EXP_RAW_LOAD = 3;
`endif

    hazard_ctrl #(.DEPTH(3), .BRANCH_PENALTY(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .dest        (dest),
        .isbranch    (isbranch),
        .issue       (issue),
        .stall       (stall),
        .inflight    (inflight)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs,
                                            input logic [4:0] rt);
        return {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
    endfunction

    task automatic present(input logic v, input logic [31:0] ins, input logic [4:0] d,
                           input logic br);
        instr_valid = v;
        instr       = ins;
        dest        = d;
        isbranch    = br;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        present(1'b0, 32'd0, 5'd0, 1'b0);
        repeat (6) tick;
    endtask

    // Holds the presented instruction until it issues; measures stall cycles, no judgement.
    task automatic wait_issue(output int stalls, output bit issued);
        stalls = 0;
        issued = 1'b0;
        for (int i = 0; i < 12 && !issued; i++) begin
            @(negedge clk);
            if (i < 4) infl_log[i] = int'(inflight);
            if (issue) issued = 1'b1;
            else if (stall) stalls++;
            tick;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        present(1'b1, enc_add(5'd2, 5'd1, 5'd1), 5'd2, 1'b0);
        #2;
        checks++;
        if (issue !== 1'b0 || stall !== 1'b0 || inflight !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: issue=%b stall=%b inflight=%0d required 0 0 0", issue, stall, inflight);
        end
        tick;
        tick;
        reset = 1'b0;
        present(1'b0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (issue !== 1'b0 || stall !== 1'b0 || inflight !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: issue=%b stall=%b inflight=%0d required 0 0 0", issue, stall, inflight);
        end
        $display("test_reset done");
        tick;
    endtask

    task automatic test_raw_alu;
        int s;
        bit ok;
        drain;
        present(1'b1, enc_i(6'b001000, 5'd0, 5'd1, 16'd5), 5'd1, 1'b0);
        wait_issue(s, ok);
        checks++;
        if (!ok || s != 0) begin
            errors++;
            $display("FAIL addi1_issue: issued=%0d stalls=%0d required 1 0", ok, s);
        end
        present(1'b1, enc_add(5'd2, 5'd1, 5'd1), 5'd2, 1'b0);
        wait_issue(s, ok);
        checks++;
        if (!ok || s != EXP_RAW_ALU) begin
            errors++;
            $display("FAIL raw_alu_stalls: issued=%0d stalls=%0d required 1 %0d", ok, s, EXP_RAW_ALU);
        end
        checks++;
`ifdef HAZARD_FORWARD_EN
        if (infl_log[0] != 1) begin
            errors++;
            $display("FAIL raw_alu_inflight: got %0d required 1", infl_log[0]);
        end
`else
        if (infl_log[0] != 1 || infl_log[1] != 1 || infl_log[2] != 1 || infl_log[3] != 0) begin
            errors++;
            $display("FAIL raw_alu_inflight: got %0d,%0d,%0d,%0d required 1,1,1,0",
                     infl_log[0], infl_log[1], infl_log[2], infl_log[3]);
        end
`endif
        $display("test_raw_alu: add stalled %0d cycles", s);
    endtask

    task automatic test_load_use;
        int s;
        bit ok;
        drain;
        present(1'b1, enc_i(6'b100011, 5'd0, 5'd3, 16'd0), 5'd3, 1'b0);
        wait_issue(s, ok);
        present(1'b1, enc_add(5'd4, 5'd3, 5'd0), 5'd4, 1'b0);
        wait_issue(s, ok);
        checks++;
        if (!ok || s != EXP_RAW_LOAD) begin
            errors++;
            $display("FAIL load_use_stalls: issued=%0d stalls=%0d required 1 %0d", ok, s, EXP_RAW_LOAD);
        end
        $display("test_load_use: add stalled %0d cycles", s);
    endtask

    task automatic test_branch;
        int s;
        bit ok;
        drain;
        present(1'b1, enc_i(6'b000100, 5'd0, 5'd0, 16'd4), 5'd0, 1'b1);
        wait_issue(s, ok);
        checks++;
        if (!ok || s != 0) begin
            errors++;
            $display("FAIL beq_issue: issued=%0d stalls=%0d required 1 0", ok, s);
        end
        present(1'b1, enc_i(6'b001000, 5'd0, 5'd9, 16'd1), 5'd9, 1'b0);
        wait_issue(s, ok);
        checks++;
        if (!ok || s != 2) begin
            errors++;
            $display("FAIL branch_penalty: issued=%0d stalls=%0d required 1 2", ok, s);
        end
        $display("test_branch: follower stalled %0d cycles", s);
    endtask

    task automatic test_zero_reg;
        int s;
        bit ok;
        drain;
        present(1'b1, enc_i(6'b001000, 5'd0, 5'd0, 16'd1), 5'd0, 1'b0);
        wait_issue(s, ok);
        present(1'b1, enc_add(5'd5, 5'd0, 5'd0), 5'd5, 1'b0);
        wait_issue(s, ok);
        checks++;
        if (!ok || s != 0) begin
            errors++;
            $display("FAIL zero_reg: issued=%0d stalls=%0d required 1 0", ok, s);
        end
        drain;
        present(1'b1, enc_i(6'b001000, 5'd0, 5'd5, 16'd1), 5'd5, 1'b0);
        wait_issue(s, ok);
        present(1'b1, enc_i(6'b101011, 5'd0, 5'd5, 16'd0), 5'd0, 1'b0);
        wait_issue(s, ok);
        checks++;
        if (!ok || s != EXP_RAW_ALU) begin
            errors++;
            $display("FAIL sw_rt_hazard: issued=%0d stalls=%0d required 1 %0d", ok, s, EXP_RAW_ALU);
        end
        drain;
        present(1'b1, enc_i(6'b001000, 5'd0, 5'd5, 16'd1), 5'd5, 1'b0);
        wait_issue(s, ok);
        present(1'b1, {6'b000010, 5'd5, 5'd5, 16'd0}, 5'd0, 1'b1);
        wait_issue(s, ok);
        checks++;
        if (!ok || s != 0) begin
            errors++;
            $display("FAIL j_no_raw: issued=%0d stalls=%0d required 1 0", ok, s);
        end
        $display("test_zero_reg done");
    endtask

    task automatic test_reset_mid;
        drain;
        present(1'b1, enc_i(6'b001000, 5'd0, 5'd7, 16'd3), 5'd7, 1'b0);
        @(negedge clk);
        checks++;
        if (issue !== 1'b1) begin
            errors++;
            $display("FAIL addi7_issue: issue=%b required 1", issue);
        end
        tick;
        reset = 1'b1;
        present(1'b1, enc_add(5'd8, 5'd7, 5'd7), 5'd8, 1'b0);
        @(negedge clk);
        checks++;
        if (issue !== 1'b0 || stall !== 1'b0 || inflight !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: issue=%b stall=%b inflight=%0d required 0 0 0", issue, stall, inflight);
        end
        tick;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (issue !== 1'b1 || stall !== 1'b0 || inflight !== 4'd0) begin
            errors++;
            $display("FAIL reset_release_issue: issue=%b stall=%b inflight=%0d required 1 0 0", issue, stall, inflight);
        end
        tick;
        $display("test_reset_mid done");
    endtask

    task automatic test_idle;
        int s;
        bit ok;
        drain;
        present(1'b1, enc_i(6'b001000, 5'd0, 5'd1, 16'd1), 5'd1, 1'b0);
        wait_issue(s, ok);
        present(1'b0, enc_add(5'd2, 5'd1, 5'd1), 5'd2, 1'b0);
        @(negedge clk);
        checks++;
        if (issue !== 1'b0 || stall !== 1'b0 || inflight !== 4'd1) begin
            errors++;
            $display("FAIL idle_outputs: issue=%b stall=%b inflight=%0d required 0 0 1", issue, stall, inflight);
        end
        repeat (3) tick;
        present(1'b1, enc_add(5'd2, 5'd1, 5'd1), 5'd2, 1'b0);
        @(negedge clk);
        checks++;
        if (issue !== 1'b1 || inflight !== 4'd0) begin
            errors++;
            $display("FAIL idle_drain: issue=%b inflight=%0d required 1 0", issue, inflight);
        end
        tick;
        drain;
        present(1'b1, enc_i(6'b000100, 5'd0, 5'd0, 16'd0), 5'd0, 1'b1);
        wait_issue(s, ok);
        present(1'b0, 32'd0, 5'd0, 1'b0);
        repeat (2) tick;
        present(1'b1, enc_i(6'b001000, 5'd0, 5'd6, 16'd1), 5'd6, 1'b0);
        @(negedge clk);
        checks++;
        if (issue !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL idle_bcnt_drain: issue=%b stall=%b required 1 0", issue, stall);
        end
        tick;
        $display("test_idle done");
    endtask

    task automatic test_back_to_back;
        drain;
        for (int k = 0; k < 5; k++) begin
            present(1'b1, enc_i(6'b001000, 5'd0, 5'(10 + k), 16'(k)), 5'(10 + k), 1'b0);
            @(negedge clk);
            checks++;
            if (issue !== 1'b1 || stall !== 1'b0 || inflight !== 4'((k < 3) ? k : 3)) begin
                errors++;
                $display("FAIL back_to_back[%0d]: issue=%b stall=%b inflight=%0d required 1 0 %0d",
                         k, issue, stall, inflight, (k < 3) ? k : 3);
            end
            tick;
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset;
        test_raw_alu;
        test_load_use;
        test_branch;
        test_zero_reg;
        test_reset_mid;
        test_idle;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
